// File: rtl/sd_fsm_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package sd_fsm_pkg;

  localparam logic [7:0] SD_DEF_PAT = 8'b0000_1011;
  localparam int         SD_DEF_LEN = 4;
  localparam bit         SD_DEF_OVL = 1'b1;

  // Width needed to hold a length value in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Low 'len' bits set; callers truncate to their pattern width.
  function automatic logic [31:0] mask(input int len);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sd_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sd_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sd_fsm_prog.sv
// Programmable serial sequence detector: run-time pattern/length/overlap,
// input-valid qualifier, registered one-cycle match pulse and match counter.
module sd_fsm_prog
  import sd_fsm_pkg::*;
#(
  parameter int                   MAX_LEN     = 8,
  parameter int                   CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PAT = MAX_LEN'(SD_DEF_PAT),
  parameter int                   DEFAULT_LEN = SD_DEF_LEN,
  parameter bit                   DEFAULT_OVL = SD_DEF_OVL,
  localparam int                  LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
  input  logic               in_valid,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_value,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               ovl_en,
  input  logic               count_clr,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cur_len
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_det;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic [LEN_W-1:0]   w_len_leg;

  always_comb begin
    w_accept = in_valid && !pat_load;
    w_hist_n = {r_hist[MAX_LEN-2:0], sequence_in};
    w_fill_n = (r_fill >= MAX_LEN_V) ? MAX_LEN_V : r_fill + LEN_W'(1);
    w_mask   = MAX_LEN'(mask(int'(r_len)));
    // A match needs at least len bits since the last clear and agreement on the low len bits.
    w_match  = w_accept && (w_fill_n >= r_len) &&
               (((w_hist_n ^ r_pat) & w_mask) == '0);
  end

  always_comb begin
    if (pat_len == '0) begin
      w_len_leg = LEN_W'(1);
    end else if (pat_len > MAX_LEN_V) begin
      w_len_leg = MAX_LEN_V;
    end else begin
      w_len_leg = pat_len;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pat  <= DEFAULT_PAT;
      r_len  <= LEN_W'(DEFAULT_LEN);
      r_ovl  <= DEFAULT_OVL;
      r_hist <= '0;
      r_fill <= '0;
      r_det  <= 1'b0;
    end else if (pat_load) begin
      r_pat  <= pat_value;
      r_len  <= w_len_leg;
      r_ovl  <= ovl_en;
      r_hist <= '0;
      r_fill <= '0;
      r_det  <= 1'b0;
    end else if (in_valid) begin
      r_det <= w_match;
      // Non-overlapping mode discards the matched bits so the next match starts fresh.
      if (w_match && !r_ovl) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_n;
        r_fill <= w_fill_n;
      end
    end else begin
      r_det <= 1'b0;
    end
  end

  sd_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_inc   (w_match),
    .i_clr   (count_clr || pat_load),
    .o_count (match_count)
  );

  assign detector_out = r_det;
  assign cur_len      = r_len;

endmodule

// File: tb/tb_sd_fsm_prog.sv
// Directed self-checking bench for sd_fsm_prog with hand-computed expectations.
module tb_sd_fsm_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic               sequence_in;
  logic               in_valid;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_value;
  logic [LEN_W-1:0]   pat_len;
  logic               ovl_en;
  logic               count_clr;
  logic               detector_out;
  logic [7:0]         match_count;
  logic [LEN_W-1:0]   cur_len;
  logic               detector_out_2;
  logic [1:0]         match_count_2;
  logic [LEN_W-1:0]   cur_len_2;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  // Clock / reset
  always #5 clock = ~clock;

  sd_fsm_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len), .ovl_en(ovl_en),
    .count_clr(count_clr), .detector_out(detector_out), .match_count(match_count),
    .cur_len(cur_len)
  );

  sd_fsm_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut_sat (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len), .ovl_en(ovl_en),
    .count_clr(count_clr), .detector_out(detector_out_2), .match_count(match_count_2),
    .cur_len(cur_len_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs sampled 1ns after the rising edge.
  task automatic step(input logic b, input logic v, input logic clr, input logic rst);
    @(negedge clock);
    sequence_in = b;
    in_valid    = v;
    count_clr   = clr;
    reset       = rst;
    pat_load    = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl, input logic v);
    @(negedge clock);
    pat_load    = 1'b1;
    pat_value   = pat;
    pat_len     = len;
    ovl_en      = ovl;
    in_valid    = v;
    sequence_in = 1'b1;
    count_clr   = 1'b0;
    reset       = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: expected pulse per valid bit queued up front, popped as bits go in.
  task automatic run_stream(input string tag, input logic [15:0] bits,
                            input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(exp[i]);
    for (int i = n - 1; i >= 0; i--) begin
      logic e;
      step(bits[i], 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      check($sformatf("%s_bit%0d", tag, n - i), {31'd0, detector_out}, {31'd0, e});
    end
  endtask

  initial begin
    reset = 1'b1; sequence_in = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    pat_value = '0; pat_len = '0; ovl_en = 1'b0; count_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_det", {31'd0, detector_out}, 32'd0);
    check("rst_cnt", {24'd0, match_count}, 32'd0);
    check("rst_len", {28'd0, cur_len}, 32'd4);

    // Default 1011, overlapping
    step(1'b0, 1'b0, 1'b0, 1'b0);
    run_stream("ovl", 16'b1011011, 16'b0001001, 7);
    check("ovl_cnt", {24'd0, match_count}, 32'd2);
    check("ovl_len", {28'd0, cur_len}, 32'd4);

    // Non-overlapping 1011
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0);
    check("nov_load_cnt", {24'd0, match_count}, 32'd0);
    run_stream("nov", 16'b1011011, 16'b0001000, 7);
    check("nov_cnt1", {24'd0, match_count}, 32'd1);
    run_stream("nov2", 16'b1011, 16'b0001, 4);
    check("nov_cnt2", {24'd0, match_count}, 32'd2);

    // in_valid gaps between bits 2 and 3
    run_stream("gap_a", 16'b10, 16'b00, 2);
    for (int g = 0; g < 3; g++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("gap_idle%0d", g), {31'd0, detector_out}, 32'd0);
    end
    run_stream("gap_b", 16'b11, 16'b01, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_pulse_len", {31'd0, detector_out}, 32'd0);
    check("gap_cnt", {24'd0, match_count}, 32'd3);

    // Load 110/len3 with a valid bit in the same cycle
    load(8'b0000_0110, 4'd3, 1'b1, 1'b1);
    check("ld110_cnt", {24'd0, match_count}, 32'd0);
    check("ld110_det", {31'd0, detector_out}, 32'd0);
    check("ld110_len", {28'd0, cur_len}, 32'd3);
    run_stream("p110", 16'b110110, 16'b001001, 6);
    check("p110_cnt", {24'd0, match_count}, 32'd2);

    // Length legalisation
    load(8'b0000_0001, 4'd0, 1'b1, 1'b0);
    check("len0_cur", {28'd0, cur_len}, 32'd1);
    run_stream("len1", 16'b1011, 16'b1011, 4);
    check("len1_cnt", {24'd0, match_count}, 32'd3);
    load(8'hA5, 4'(MAX_LEN + 3), 1'b1, 1'b0);
    check("lenmax_cur", {28'd0, cur_len}, 32'd8);
    run_stream("lenmax", 16'b10100101, 16'b00000001, 8);
    check("lenmax_cnt", {24'd0, match_count}, 32'd1);

    // Saturation on the 2-bit counter, then count_clr racing a match
    load(8'b0000_0001, 4'd1, 1'b1, 1'b0);
    check("sat_clr8", {24'd0, match_count}, 32'd0);
    check("sat_clr2", {30'd0, match_count_2}, 32'd0);
    run_stream("sat", 16'b111111, 16'b111111, 6);
    check("sat_cnt8", {24'd0, match_count}, 32'd6);
    check("sat_cnt2", {30'd0, match_count_2}, 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_race_det", {31'd0, detector_out}, 32'd1);
    check("clr_race_cnt", {24'd0, match_count}, 32'd0);
    check("clr_race_cnt2", {30'd0, match_count_2}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("after_clr_cnt", {24'd0, match_count}, 32'd1);

    // Reset mid-pattern loses partial progress
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
    run_stream("pre_rst", 16'b101, 16'b000, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_det", {31'd0, detector_out}, 32'd0);
    check("mid_rst_len", {28'd0, cur_len}, 32'd4);
    run_stream("post_rst", 16'b1011, 16'b0001, 4);
    check("post_rst_cnt", {24'd0, match_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
